// File: rtl/ram_arbiter_2p.sv
// Two-port round-robin arbiter in front of a single ram_8x8: one access in flight, IDLE -> CMD -> DONE.
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority on simultaneous requests instead of round robin.
module ram_arbiter_2p #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_enable,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dados_in,
    input  logic [DATA_W-1:0] ram_dados_out,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic              winner_s;
    logic              any_req_s;

    logic              ram_enable_r;
    logic              ram_write_enable_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_dados_in_r;
    logic              r0_ack_r;
    logic              r1_ack_r;
    logic [DATA_W-1:0] r0_rdata_r;
    logic [DATA_W-1:0] r1_rdata_r;
    logic              busy_r;
    logic              owner_r;

    logic              ram_enable_next_s;
    logic              ram_write_enable_next_s;
    logic [ADDR_W-1:0] ram_addr_next_s;
    logic [DATA_W-1:0] ram_dados_in_next_s;
    logic              r0_ack_next_s;
    logic              r1_ack_next_s;
    logic [DATA_W-1:0] r0_rdata_next_s;
    logic [DATA_W-1:0] r1_rdata_next_s;
    logic              busy_next_s;
    logic              owner_next_s;

    assign any_req_s = r0_req | r1_req;

`ifdef ARB_FIXED_PRIO_EN
    // Port 0 always takes a tie; port 1 is served only when port 0 is quiet.
    always_comb begin
        if (r0_req) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
    end
`else
    logic last_grant_r;

    // Round robin: on a tie the port that was not served last wins.
    always_comb begin
        if (r0_req && r1_req) begin
            winner_s = ~last_grant_r;
        end else if (r1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Remember who was served; reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (state_r == DONE) begin
            last_grant_r <= owner_r;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_next_s = CMD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CMD:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the output registers; RAM outputs stay 0 outside CMD.
    always_comb begin
        ram_enable_next_s       = 1'b0;
        ram_write_enable_next_s = 1'b0;
        ram_addr_next_s         = {ADDR_W{1'b0}};
        ram_dados_in_next_s     = {DATA_W{1'b0}};
        r0_ack_next_s           = 1'b0;
        r1_ack_next_s           = 1'b0;
        r0_rdata_next_s         = r0_rdata_r;
        r1_rdata_next_s         = r1_rdata_r;
        busy_next_s             = 1'b0;
        owner_next_s            = owner_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    ram_enable_next_s = 1'b1;
                    busy_next_s       = 1'b1;
                    owner_next_s      = winner_s;
                    if (winner_s) begin
                        ram_write_enable_next_s = r1_we;
                        ram_addr_next_s         = r1_addr;
                        ram_dados_in_next_s     = r1_wdata;
                    end else begin
                        ram_write_enable_next_s = r0_we;
                        ram_addr_next_s         = r0_addr;
                        ram_dados_in_next_s     = r0_wdata;
                    end
                end else begin
                    busy_next_s = 1'b0;
                end
            end
            CMD: begin
                busy_next_s = 1'b1;
                if (owner_r) begin
                    r1_ack_next_s = 1'b1;
                end else begin
                    r0_ack_next_s = 1'b1;
                end
                // Read data is valid from the RAM only while it is enabled for a read.
                if (!ram_write_enable_r && owner_r) begin
                    r1_rdata_next_s = ram_dados_out;
                end else if (!ram_write_enable_r) begin
                    r0_rdata_next_s = ram_dados_out;
                end else begin
                    r0_rdata_next_s = r0_rdata_r;
                end
            end
            DONE: begin
                busy_next_s = 1'b0;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_enable_r       <= 1'b0;
            ram_write_enable_r <= 1'b0;
            ram_addr_r         <= {ADDR_W{1'b0}};
            ram_dados_in_r     <= {DATA_W{1'b0}};
            r0_ack_r           <= 1'b0;
            r1_ack_r           <= 1'b0;
            r0_rdata_r         <= {DATA_W{1'b0}};
            r1_rdata_r         <= {DATA_W{1'b0}};
            busy_r             <= 1'b0;
            owner_r            <= 1'b0;
        end else begin
            ram_enable_r       <= ram_enable_next_s;
            ram_write_enable_r <= ram_write_enable_next_s;
            ram_addr_r         <= ram_addr_next_s;
            ram_dados_in_r     <= ram_dados_in_next_s;
            r0_ack_r           <= r0_ack_next_s;
            r1_ack_r           <= r1_ack_next_s;
            r0_rdata_r         <= r0_rdata_next_s;
            r1_rdata_r         <= r1_rdata_next_s;
            busy_r             <= busy_next_s;
            owner_r            <= owner_next_s;
        end
    end

    assign ram_enable       = ram_enable_r;
    assign ram_write_enable = ram_write_enable_r;
    assign ram_addr         = ram_addr_r;
    assign ram_dados_in     = ram_dados_in_r;
    assign r0_ack           = r0_ack_r;
    assign r1_ack           = r1_ack_r;
    assign r0_rdata         = r0_rdata_r;
    assign r1_rdata         = r1_rdata_r;
    assign busy             = busy_r;
    assign owner            = owner_r;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Randomized bench for ram_arbiter_2p against a transaction-level model of grants, timing and memory.
module tb_ram_arbiter_2p;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr, ram_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, ram_dados_in;
    logic          r0_ack, r1_ack, ram_enable, ram_write_enable, busy, owner;
    wire  [DW-1:0] ram_dados_out;

    always #5 clk = ~clk;

    ram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .ram_enable(ram_enable), .ram_write_enable(ram_write_enable),
        .ram_addr(ram_addr), .ram_dados_in(ram_dados_in), .ram_dados_out(ram_dados_out),
        .busy(busy), .owner(owner)
    );

    // Behavioural ram_8x8: output floats unless enabled for a read.
    logic [DW-1:0] ram_mem [0:7];
    always @(posedge clk) begin
        if (ram_enable && ram_write_enable) ram_mem[ram_addr] <= ram_dados_in;
    end
    assign ram_dados_out = (ram_enable && !ram_write_enable) ? ram_mem[ram_addr] : 8'bz;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: requesters (0 free, 1 waiting, 2 granted) and the access in flight.
    int            rq_st [2];
    logic          rq_we [2];
    logic [AW-1:0] rq_addr [2];
    logic [DW-1:0] rq_wd [2];
    bit            g_valid;
    int            g_cyc, g_port, free_cyc, last_grant, w;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;
    logic [DW-1:0] mem_m [8];
    logic [DW-1:0] exp_rd [2];
    bit            rst_now, rst_prev, drop_en, rst_en;
    bit            e_en, e_ack, e_busy;
    int            p_new;
    logic          req_v [2];

    initial begin
        for (int i = 0; i < 8; i++) begin
            ram_mem[i] = 8'h00;
            mem_m[i]   = 8'h00;
        end
        reset = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 3'd0; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 3'd0; r1_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_enable", ram_enable, 1'b0);
        chk("rst_ram_we", ram_write_enable, 1'b0);
        chk("rst_ram_addr", ram_addr, 3'd0);
        chk("rst_ram_din", ram_dados_in, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_acks", {r1_ack, r0_ack}, 2'b00);
        chk("rst_r0_rdata", r0_rdata, 8'h00);
        chk("rst_r1_rdata", r1_rdata, 8'h00);

        rq_st[0] = 0; rq_st[1] = 0;
        g_valid = 1'b0; g_cyc = -10; g_port = 0; g_we = 1'b0; g_addr = 3'd0; g_wd = 8'h00;
        free_cyc = 0; last_grant = 1;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        rst_prev = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            // First 60 cycles: both ports saturated, req held; afterwards random traffic.
            if (cyc < 60) begin
                p_new = 100; drop_en = 1'b0; rst_en = 1'b0;
            end else begin
                p_new = 30; drop_en = 1'b1; rst_en = 1'b1;
            end
            if (rst_prev) begin
                g_valid = 1'b0; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
                last_grant = 1; free_cyc = cyc; rq_st[0] = 0; rq_st[1] = 0;
            end
            if (g_valid && cyc > g_cyc + 2) begin
                g_valid = 1'b0;
                rq_st[g_port] = 0;
            end
            // Reset only lands on a read's CMD cycle so memory contents stay known.
            rst_now = rst_en && g_valid && (cyc == g_cyc + 1) && !g_we && ($urandom_range(0, 7) == 0);
            for (int p = 0; p < 2; p++) begin
                if (rq_st[p] == 0 && $urandom_range(0, 99) < p_new) begin
                    rq_st[p]   = 1;
                    rq_we[p]   = 1'($urandom_range(0, 1));
                    rq_addr[p] = 3'($urandom_range(0, 7));
                    rq_wd[p]   = 8'($urandom);
                end
                req_v[p] = (rq_st[p] == 1) || (rq_st[p] == 2 && (!drop_en || $urandom_range(0, 1) == 1));
            end
            reset    = rst_now;
            r0_req   = req_v[0]; r0_we = rq_we[0]; r0_addr = rq_addr[0]; r0_wdata = rq_wd[0];
            r1_req   = req_v[1]; r1_we = rq_we[1]; r1_addr = rq_addr[1]; r1_wdata = rq_wd[1];

            if (!rst_now && cyc >= free_cyc && (rq_st[0] == 1 || rq_st[1] == 1)) begin
                if (rq_st[0] == 1 && rq_st[1] == 1) begin
`ifdef ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = 1 - last_grant;
`endif
                end else begin
                    w = (rq_st[1] == 1) ? 1 : 0;
                end
                g_valid = 1'b1; g_cyc = cyc; g_port = w;
                g_we = rq_we[w]; g_addr = rq_addr[w]; g_wd = rq_wd[w];
                rq_st[w] = 2; free_cyc = cyc + 3; last_grant = w;
                if (g_we) mem_m[g_addr] = g_wd;
            end
            rst_prev = rst_now;

            e_en   = g_valid && (cyc == g_cyc + 1);
            e_ack  = g_valid && (cyc == g_cyc + 2);
            e_busy = e_en || e_ack;
            if (e_ack && !g_we) exp_rd[g_port] = mem_m[g_addr];

            @(negedge clk);
            chk("ram_enable", ram_enable, e_en);
            chk("busy", busy, e_busy);
            chk("ram_we", ram_write_enable, e_en ? g_we : 1'b0);
            chk("ram_addr", ram_addr, e_en ? g_addr : 3'd0);
            chk("ram_din", ram_dados_in, e_en ? g_wd : 8'h00);
            if (e_busy) chk("owner", owner, g_port[0]);
            chk("r0_ack", r0_ack, e_ack && g_port == 0);
            chk("r1_ack", r1_ack, e_ack && g_port == 1);
            chk("r0_rdata", r0_rdata, exp_rd[0]);
            chk("r1_rdata", r1_rdata, exp_rd[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
